// File: rtl/psum_requant_drain.sv
// Drains signed 32-bit partial sums from the psum BRAM, requantises each to int8
// (optional ReLU, arithmetic shift, saturation) and packs four per word into the output BRAM.
module psum_requant_drain #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned NUM_BYTE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [31:0]           i_count,
    input  logic [4:0]            i_shift,
    input  logic                  i_relu_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] psum_addr,
    output logic                  psum_enb,
    input  logic [DATA_WIDTH-1:0] psum_odat,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_idat,
    output logic [NUM_BYTE-1:0]   out_wren,
    output logic                  out_enb
);

    localparam int unsigned LW = $clog2(NUM_BYTE);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'((2 ** (BIT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e                  state_q;
    logic [31:0]             count_q;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [ADDR_WIDTH-1:0]   rd_idx_q;
    logic [ADDR_WIDTH-1:0]   wr_idx_q;
    logic [LW-1:0]           lane_q;
    logic [DATA_WIDTH-1:0]   pack_q;
    // Read data valid / last-element flags, aligned with the BRAM's 1-cycle read latency.
    logic                    dvalid_q;
    logic                    dlast_q;

    logic                    rd_last;
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [DATA_WIDTH-1:0] y;
    logic [BIT_WIDTH-1:0]    elem;
    logic [DATA_WIDTH-1:0]   pack_next;
    logic [NUM_BYTE-1:0]     wren_next;
    logic                    write_fire;

    assign psum_addr = rd_idx_q;
    assign rd_last   = (rd_idx_q == ADDR_WIDTH'(count_q - 32'd1));

    always_comb begin
        x = $signed(psum_odat);
        if (relu_q && x < 0) begin
            x = '0;
        end
        y = x >>> shift_q;
        if (y > SAT_MAX) begin
            elem = SAT_MAX[BIT_WIDTH-1:0];
        end else if (y < SAT_MIN) begin
            elem = SAT_MIN[BIT_WIDTH-1:0];
        end else begin
            elem = y[BIT_WIDTH-1:0];
        end
        pack_next = pack_q;
        wren_next = '0;
        for (int i = 0; i < NUM_BYTE; i++) begin
            if (lane_q == LW'(i)) begin
                pack_next[i*BIT_WIDTH +: BIT_WIDTH] = elem;
            end
            wren_next[i] = (LW'(i) <= lane_q);
        end
        write_fire = dvalid_q && ((lane_q == LW'(NUM_BYTE - 1)) || dlast_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            lane_q   <= '0;
            pack_q   <= '0;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            psum_enb <= 1'b0;
            out_addr <= '0;
            out_idat <= '0;
            out_wren <= '0;
            out_enb  <= 1'b0;
        end else begin
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            out_enb  <= 1'b0;
            out_wren <= '0;

            if (dvalid_q) begin
                if (write_fire) begin
                    out_enb  <= 1'b1;
                    out_addr <= wr_idx_q;
                    out_idat <= pack_next;
                    out_wren <= wren_next;
                    wr_idx_q <= wr_idx_q + ADDR_WIDTH'(1);
                    pack_q   <= '0;
                    lane_q   <= '0;
                end else begin
                    pack_q <= pack_next;
                    lane_q <= lane_q + LW'(1);
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        count_q  <= i_count;
                        shift_q  <= i_shift;
                        relu_q   <= i_relu_en;
                        rd_idx_q <= '0;
                        wr_idx_q <= '0;
                        lane_q   <= '0;
                        pack_q   <= '0;
                        o_busy   <= 1'b1;
                        if (i_count == 32'd0) begin
                            state_q <= StDone;
                        end else begin
                            state_q  <= StRead;
                            psum_enb <= 1'b1;
                        end
                    end
                end
                StRead: begin
                    rd_idx_q <= rd_idx_q + ADDR_WIDTH'(1);
                    dvalid_q <= 1'b1;
                    dlast_q  <= rd_last;
                    if (rd_last) begin
                        psum_enb <= 1'b0;
                        state_q  <= StDrain;
                    end
                end
                StDrain: begin
                    state_q <= StDone;
                end
                StDone: begin
                    // First DONE cycle carries the final write; the pulse follows it.
                    if (!o_done) begin
                        o_done <= 1'b1;
                    end else begin
                        o_done  <= 1'b0;
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_requant_drain.sv
// Scoreboard bench for psum_requant_drain: a psum BRAM model feeds the DUT and every
// output write is checked against an expected queue (address, data, byte enables, cycle).
module tb_psum_requant_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_count = '0;
    logic [4:0]  i_shift = '0;
    logic        i_relu_en = 1'b0;
    logic        o_busy, o_done, psum_enb, out_enb;
    logic [31:0] psum_addr, out_addr, out_idat;
    logic [31:0] psum_odat = '0;
    logic [3:0]  out_wren;

    psum_requant_drain dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_count   (i_count),
        .i_shift   (i_shift),
        .i_relu_en (i_relu_en),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .psum_addr (psum_addr),
        .psum_enb  (psum_enb),
        .psum_odat (psum_odat),
        .out_addr  (out_addr),
        .out_idat  (out_idat),
        .out_wren  (out_wren),
        .out_enb   (out_enb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wren;
        int          cyc;
    } wr_t;

    wr_t         sbq[$];
    logic [31:0] mem[128];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          rd_expect = 0;
    int          wr_seen = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) if (psum_enb) psum_odat <= mem[psum_addr[6:0]];

    // Monitor: every write must match the head of the scoreboard; reads must be sequential.
    always @(negedge clk) begin
        if (out_enb) begin
            wr_t e;
            total++;
            wr_seen++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write addr=%0h data=%h wren=%b cyc=%0d",
                         out_addr, out_idat, out_wren, cyc);
            end else begin
                e = sbq.pop_front();
                if (out_addr !== e.addr || out_idat !== e.data || out_wren !== e.wren ||
                    cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL write got addr=%0h data=%h wren=%b cyc=%0d want addr=%0h data=%h wren=%b cyc=%0d",
                             out_addr, out_idat, out_wren, cyc, e.addr, e.data, e.wren, e.cyc);
                end
            end
        end
        if (psum_enb) begin
            total++;
            if (psum_addr !== 32'(rd_expect)) begin
                bad++;
                $display("FAIL psum_addr got=%0d want=%0d", psum_addr, rd_expect);
            end
            rd_expect++;
        end
    end

    function automatic logic [7:0] rq(input logic [31:0] x, input int sh, input bit relu);
        longint v;
        v = longint'($signed(x));
        if (relu && v < 0) v = 0;
        v = v >>> sh;
        if (v > 127) return 8'h7F;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    task automatic push_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                             input int c);
        wr_t e;
        e.addr = a; e.data = d; e.wren = m; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic push_model(input int n, input int sh, input bit relu, input int t0);
        logic [31:0] w = '0;
        logic [3:0]  m = '0;
        int lane = 0;
        int wa = 0;
        for (int e = 0; e < n; e++) begin
            w[8*lane +: 8] = rq(mem[e], sh, relu);
            m[lane] = 1'b1;
            if (lane == 3 || e == n - 1) begin
                push_word(32'(wa), w, m, t0 + e + 2);
                wa++; w = '0; m = '0; lane = 0;
            end else begin
                lane++;
            end
        end
    endtask

    // Called at #1 after a rising edge; returns the cycle number in which READ/DONE starts.
    task automatic start(input int n, input int sh, input bit relu, output int t0);
        i_count = 32'(n); i_shift = 5'(sh); i_relu_en = relu; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (o_done) begin
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({o_busy, o_done, psum_enb, out_enb, out_wren} !== 8'd0 || psum_addr !== 0 ||
            out_addr !== 0 || out_idat !== 0) begin
            bad++;
            $display("FAIL reset_outputs busy=%b done=%b penb=%b oenb=%b wren=%b paddr=%h oaddr=%h idat=%h",
                     o_busy, o_done, psum_enb, out_enb, out_wren, psum_addr, out_addr, out_idat);
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input bit relu, input logic [31:0] exp_word);
        int t0, dc;
        mem[0] = 32'd10; mem[1] = -32'sd20; mem[2] = 32'd300; mem[3] = -32'sd300;
        rd_expect = 0;
        start(4, 0, relu, t0);
        push_word(32'd0, exp_word, 4'b1111, t0 + 5);
        wait_done(dc);
        total++;
        if (dc !== t0 + 6) begin
            bad++;
            $display("FAIL basic_done_cycle relu=%0d got=%0d want=%0d", relu, dc, t0 + 6);
        end
        @(posedge clk); #1;
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || sbq.size() != 0 || rd_expect != 4) begin
            bad++;
            $display("FAIL basic_after relu=%0d done=%b busy=%b pending=%0d reads=%0d want 0 0 0 4",
                     relu, o_done, o_busy, sbq.size(), rd_expect);
        end
    endtask

    task automatic test_tail;
        int t0, dc;
        for (int i = 0; i < 6; i++) mem[i] = 32'(256 * (i + 1));
        rd_expect = 0;
        start(6, 8, 1'b0, t0);
        push_word(32'd0, 32'h04030201, 4'b1111, t0 + 5);
        push_word(32'd1, 32'h00000605, 4'b0011, t0 + 7);
        wait_done(dc);
        total++;
        if (dc !== t0 + 8 || sbq.size() != 0 || rd_expect != 6) begin
            bad++;
            $display("FAIL tail done_cyc=%0d want=%0d pending=%0d reads=%0d want 0 6",
                     dc, t0 + 8, sbq.size(), rd_expect);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int t0, dc;
        rd_expect = 0;
        start(0, 0, 1'b0, t0);
        wait_done(dc);
        total++;
        if (dc !== t0 + 1) begin
            bad++;
            $display("FAIL zero_done_cycle got=%0d want=%0d", dc, t0 + 1);
        end
        @(posedge clk); #1;
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || rd_expect != 0) begin
            bad++;
            $display("FAIL zero_after busy=%b done=%b reads=%0d want 0 0 0", o_busy, o_done,
                     rd_expect);
        end
    endtask

    task automatic test_reset_mid;
        int t0, dc, sh, w0;
        bit relu;
        for (int i = 0; i < 100; i++) mem[i] = $urandom;
        rd_expect = 0;
        start(100, 3, 1'b0, t0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({o_busy, o_done, psum_enb, out_enb, out_wren} !== 8'd0 || psum_addr !== 0 ||
            out_addr !== 0 || out_idat !== 0) begin
            bad++;
            $display("FAIL midreset_outputs busy=%b done=%b penb=%b oenb=%b paddr=%h idat=%h want all 0",
                     o_busy, o_done, psum_enb, out_enb, psum_addr, out_idat);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                bad++;
                $display("FAIL midreset_hold done=%b busy=%b want 0 0", o_done, o_busy);
            end
        end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        sh = $urandom_range(0, 20);
        relu = 1'($urandom_range(0, 1));
        for (int i = 0; i < 100; i++) mem[i] = $urandom;
        rd_expect = 0;
        w0 = wr_seen;
        start(100, sh, relu, t0);
        push_model(100, sh, relu, t0);
        wait_done(dc);
        total++;
        if (dc !== t0 + 102 || sbq.size() != 0 || wr_seen - w0 != 25 || rd_expect != 100) begin
            bad++;
            $display("FAIL rerun100 done_cyc=%0d want=%0d pending=%0d writes=%0d want 25 reads=%0d",
                     dc, t0 + 102, sbq.size(), wr_seen - w0, rd_expect);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_restart_ignored;
        int t0, dc, w0;
        for (int i = 0; i < 8; i++) mem[i] = $urandom_range(0, 4000) - 2000;
        rd_expect = 0;
        w0 = wr_seen;
        start(8, 2, 1'b1, t0);
        push_model(8, 2, 1'b1, t0);
        repeat (2) @(posedge clk);
        #1;
        i_count = 32'd2; i_shift = 5'd0; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done(dc);
        total++;
        if (dc !== t0 + 10 || sbq.size() != 0 || wr_seen - w0 != 2 || rd_expect != 8) begin
            bad++;
            $display("FAIL restart_ignored done_cyc=%0d want=%0d pending=%0d writes=%0d want 2",
                     dc, t0 + 10, sbq.size(), wr_seen - w0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int t0, dc;
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        rd_expect = 0;
        start(5, 4, 1'b0, t0);
        push_model(5, 4, 1'b0, t0);
        wait_done(dc);
        total++;
        if (dc !== t0 + 7) begin
            bad++;
            $display("FAIL b2b_first_done got=%0d want=%0d", dc, t0 + 7);
        end
        // Start held during the o_done cycle must be ignored.
        i_count = 32'd7; i_shift = 5'd9; i_relu_en = 1'b1; i_start = 1'b1;
        @(posedge clk); #1;
        total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_start_on_done busy=%b done=%b want 0 0", o_busy, o_done);
        end
        rd_expect = 0;
        start(7, 9, 1'b1, t0);
        push_model(7, 9, 1'b1, t0);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_busy got=%b want=1", o_busy);
        end
        wait_done(dc);
        total++;
        if (dc !== t0 + 9 || sbq.size() != 0 || rd_expect != 7) begin
            bad++;
            $display("FAIL b2b_second done_cyc=%0d want=%0d pending=%0d reads=%0d want 7",
                     dc, t0 + 9, sbq.size(), rd_expect);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        test_basic(1'b0, 32'h807FEC0A);
        test_basic(1'b1, 32'h007F000A);
        test_tail();
        test_zero();
        test_reset_mid();
        test_restart_ignored();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
